// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter data-RAM arbiter.
package dm_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   localparam logic M_CPU  = 1'b0;
   localparam logic M_LOAD = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GNT  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Winner among the requesters; prefer1 breaks a tie towards the loader.
   function automatic logic arb_pick(input logic [1:0] req, input logic prefer1);
      logic pick;
      if (req == 2'b11) begin
         pick = prefer1 ? M_LOAD : M_CPU;
      end else if (req == 2'b10) begin
         pick = M_LOAD;
      end else begin
         pick = M_CPU;
      end
      return pick;
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Per-master request/grant/response bundle between a master and dm_arbiter.
interface dm_arbiter_if
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic                  req;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W/8-1:0]   be;
   logic [DATA_W-1:0]     wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dm_ram.sv
// Single-port data RAM: synchronous byte-enabled write, registered read, no reset.
module dm_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);
   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

   function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   lanes);
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (lanes[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   // One access per enabled cycle: write the enabled lanes, or capture the read word.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem_r[addr] <= lane_merge(mem_r[addr], wdata, be);
      end else if (en) begin
         rdata <= mem_r[addr];
      end
   end
endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter (m0 = CPU, m1 = loader) in front of a shared data RAM.
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise m0 always wins ties.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   dm_arbiter_if.slave  m0,
   dm_arbiter_if.slave  m1,
   output logic         busy,
   output logic [15:0]  wait_cnt
);
   localparam int BE_W = DATA_W / 8;

   state_t              state_r, state_next_s;
   logic                winner_r, winner_next_s, other_s;
   logic [1:0]          req_s, gnt_r, gnt_next_s, rvalid_r, rvalid_next_s;
   logic                busy_r, prefer1_s, stall_s;
   logic [15:0]         wait_cnt_r;
   logic                op_we_s, ram_en_s;
   logic [ADDR_W-1:0]   op_addr_s;
   logic [BE_W-1:0]     op_be_s;
   logic [DATA_W-1:0]   op_wdata_s, ram_q_s, hold0_r, hold1_r;

   assign req_s      = {m1.req, m0.req};
   assign other_s    = ~winner_r;
   assign op_we_s    = (winner_r == M_LOAD) ? m1.we    : m0.we;
   assign op_addr_s  = (winner_r == M_LOAD) ? m1.addr  : m0.addr;
   assign op_be_s    = (winner_r == M_LOAD) ? m1.be    : m0.be;
   assign op_wdata_s = (winner_r == M_LOAD) ? m1.wdata : m0.wdata;
   assign ram_en_s   = (state_r == S_GNT);

`ifdef DM_ARB_RR_EN
   logic last_r;

   // Last granted master; starts at m1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_r <= M_LOAD;
      end else if (state_r == S_GNT) begin
         last_r <= winner_r;
      end
   end
   assign prefer1_s = (last_r == M_CPU);
`else
   assign prefer1_s = 1'b0;
`endif

   // Next state, next winner and the grant/response strobes for the coming cycle.
   always_comb begin
      state_next_s  = state_r;
      winner_next_s = winner_r;
      gnt_next_s    = 2'b00;
      rvalid_next_s = 2'b00;
      case (state_r)
         S_IDLE, S_RESP: begin
            if (|req_s) begin
               state_next_s  = S_GNT;
               winner_next_s = arb_pick(req_s, prefer1_s);
            end else begin
               state_next_s  = S_IDLE;
            end
         end
         S_GNT: begin
            if (!op_we_s) begin
               state_next_s  = S_RESP;
            end else if (req_s[other_s]) begin
               state_next_s  = S_GNT;
               winner_next_s = other_s;
            end else begin
               state_next_s  = S_IDLE;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
      if (state_next_s == S_GNT) begin
         gnt_next_s[winner_next_s] = 1'b1;
      end else if (state_next_s == S_RESP) begin
         rvalid_next_s[winner_next_s] = 1'b1;
      end else begin
         gnt_next_s = 2'b00;
      end
   end

   // FSM state and registered strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= S_IDLE;
         winner_r <= M_CPU;
         gnt_r    <= 2'b00;
         rvalid_r <= 2'b00;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         winner_r <= winner_next_s;
         gnt_r    <= gnt_next_s;
         rvalid_r <= rvalid_next_s;
         busy_r   <= (state_next_s != S_IDLE);
      end
   end

   // A cycle stalls when some master requests without holding the grant.
   assign stall_s = |(req_s & ~gnt_r);

   // Saturating stall counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_r <= 16'h0000;
      end else if (stall_s && (wait_cnt_r != 16'hFFFF)) begin
         wait_cnt_r <= wait_cnt_r + 16'd1;
      end
   end

   // Per-master copy of the last delivered read word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold0_r <= '0;
         hold1_r <= '0;
      end else begin
         if (rvalid_r[0]) hold0_r <= ram_q_s;
         if (rvalid_r[1]) hold1_r <= ram_q_s;
      end
   end

   dm_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .en    (ram_en_s),
      .we    (op_we_s),
      .addr  (op_addr_s),
      .be    (op_be_s),
      .wdata (op_wdata_s),
      .rdata (ram_q_s)
   );

   assign m0.gnt    = gnt_r[0];
   assign m1.gnt    = gnt_r[1];
   assign m0.rvalid = rvalid_r[0];
   assign m1.rvalid = rvalid_r[1];
   assign m0.rdata  = rvalid_r[0] ? ram_q_s : hold0_r;
   assign m1.rdata  = rvalid_r[1] ? ram_q_s : hold1_r;
   assign busy      = busy_r;
   assign wait_cnt  = wait_cnt_r;
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word address width of the shared data RAM (2^ADDR_W words).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; byte-enable width SHALL be DATA_W/8.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mN_req  in  1  (N = 0 CPU, 1 loader) request, held until mN_gnt.
REQ-006 mN_we  in  1  1 = write, 0 = read.
REQ-007 mN_addr  in  ADDR_W  word address.
REQ-008 mN_be  in  DATA_W/8  write byte enables.
REQ-009 mN_wdata  in  DATA_W  write data.
REQ-010 mN_gnt  out  1  one-cycle grant pulse; the access is performed in that cycle.
REQ-011 mN_rvalid  out  1  one-cycle pulse qualifying mN_rdata.
REQ-012 mN_rdata  out  DATA_W  read data, valid only with mN_rvalid.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 wait_cnt  out  16  saturating count of cycles in which any mN_req is high with no mN_gnt.

Function
REQ-015 The FSM SHALL have three states: IDLE, GNT and RESP.
REQ-016 IDLE: if any req is sampled high, SHALL go to GNT with the winner latched; otherwise SHALL stay in IDLE.
REQ-017 GNT: SHALL assert the winner's gnt; the RAM SHALL perform the winner's operation at the closing edge; writes SHALL update only lanes with be=1.
REQ-018 GNT, write: SHALL go to GNT (new arbitration) if any req other than the one just granted is pending, else to IDLE.
REQ-019 GNT, read: SHALL go to RESP; in RESP the winner's rvalid SHALL be 1 and rdata SHALL be the RAM word.
REQ-020 RESP: SHALL go to GNT if any req is pending, else to IDLE.
REQ-021 A req still high in the cycle after its gnt SHALL count as a new request.
REQ-022 Latency: read = req to gnt 1 cycle, gnt to rvalid 1 cycle; write = commit at the gnt edge.
REQ-023 The non-granted master's gnt and rvalid SHALL stay 0; its rdata SHALL hold its last value.
REQ-024 Exactly one gnt SHALL be high per cycle at most; gnt and rvalid for the same master SHALL never overlap.
REQ-025 wait_cnt SHALL increment by 1 per stalled cycle (not per master) and SHALL saturate at 0xFFFF.
REQ-026 Read-after-write to the same address in consecutive grants SHALL return the new data.

Reset
REQ-027 rst low SHALL force: state IDLE, all gnt/rvalid 0, rdata 0, busy 0, wait_cnt 0, round-robin pointer = 1 (m0 wins the first tie).
REQ-028 rst asserted during GNT SHALL suppress the RAM write; rst asserted during RESP SHALL drop rvalid.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-030 With DM_ARB_RR_EN defined: on a tie, the master not granted last SHALL win; the pointer SHALL update on every gnt.
REQ-031 With DM_ARB_RR_EN undefined: m0 SHALL always win ties, and the pointer register SHALL be absent.

Structure
REQ-032 Package dm_arb_pkg SHALL hold the state enum, the master ID constants (M_CPU=0, M_LOAD=1) and the default ADDR_W/DATA_W.
REQ-033 The RAM SHALL be the sub-module dm_ram: single-port, synchronous write, registered read, with byte enables.

Verification
REQ-034 Reset, then m0 writes 0xDEADBEEF to address 5 with be=4'hF, then reads address 5 -> gnt one cycle after each req; rvalid on the next cycle with rdata=0xDEADBEEF.
REQ-035 m0 and m1 both request in the same cycle (RR build) -> m0 granted first, m1 granted next; both held continuously -> grants alternate 0,1,0,1; no-RR build -> m0 always granted.
REQ-036 Word holds 0x11223344; write be=4'b0010, wdata 0xAABBCCDD -> readback 0x1122CC44.
REQ-037 Drop rst mid-GNT of a write of 0x12345678 to address 7 (old value 0) -> address 7 reads 0; all outputs return to their reset values immediately.
REQ-038 m1 held requesting while m0 owns 3 back-to-back reads -> wait_cnt increases exactly by the stalled cycles; with wait_cnt forced to 0xFFFE, 3 further stalled cycles -> 0xFFFF.
